// File: rtl/amb_cozucu.sv
// Decode-to-execute stage register for RV32I ALU-class instructions (OP, OP-IMM, LUI, AUIPC).
// Optional illegal-instruction counter output hata_sayisi_o enabled by `define AMB_COZUCU_HATA_SAYACI_EN.

`ifndef AMB_GECIR
`define AMB_GECIR    4'd0
`define AMB_TOPLAMA  4'd1
`define AMB_CIKARMA  4'd2
`define AMB_SLL      4'd3
`define AMB_SLT      4'd4
`define AMB_SLTU     4'd5
`define AMB_XOR      4'd6
`define AMB_SRL      4'd7
`define AMB_SRA      4'd8
`define AMB_OR       4'd9
`define AMB_AND      4'd10
`endif

module amb_cozucu #(
   parameter int VERI_GENISLIGI = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [31:0]               buyruk_i,
   input  logic [VERI_GENISLIGI-1:0] ps_i,
   input  logic [VERI_GENISLIGI-1:0] rs1_deger_i,
   input  logic [VERI_GENISLIGI-1:0] rs2_deger_i,
   input  logic                      gecerli_i,
   output logic                      hazir_o,
   input  logic                      bosalt_i,
   output logic [3:0]                kontrol_o,
   output logic [VERI_GENISLIGI-1:0] deger1_o,
   output logic [VERI_GENISLIGI-1:0] deger2_o,
   output logic [4:0]                rd_o,
   output logic                      yaz_o,
   output logic                      hata_o,
   output logic                      gecerli_o,
   input  logic                      hazir_i
`ifdef AMB_COZUCU_HATA_SAYACI_EN
   ,
   output logic [15:0]               hata_sayisi_o
`endif
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] F7_SIFIR   = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   logic [6:0]                opcode;
   logic [2:0]                funct3;
   logic [6:0]                funct7;
   logic [4:0]                rd;
   logic [VERI_GENISLIGI-1:0] imm_i;
   logic [VERI_GENISLIGI-1:0] imm_u;
   logic [VERI_GENISLIGI-1:0] shamt;

   logic [3:0]                d_kontrol;
   logic [VERI_GENISLIGI-1:0] d_deger1;
   logic [VERI_GENISLIGI-1:0] d_deger2;
   logic                      d_yasal;
   logic                      d_yaz;
   logic                      kabul;

   assign opcode = buyruk_i[6:0];
   assign rd     = buyruk_i[11:7];
   assign funct3 = buyruk_i[14:12];
   assign funct7 = buyruk_i[31:25];
   assign imm_i  = {{(VERI_GENISLIGI-12){buyruk_i[31]}}, buyruk_i[31:20]};
   assign imm_u  = {buyruk_i[31:12], 12'b0};
   assign shamt  = {{(VERI_GENISLIGI-5){1'b0}}, buyruk_i[24:20]};

   // Stage advances whenever the slot is empty or is being drained this cycle.
   assign hazir_o = !gecerli_o || hazir_i;
   assign kabul   = gecerli_i && hazir_o && !bosalt_i;

   always_comb begin
      d_kontrol = `AMB_GECIR;
      d_deger1  = '0;
      d_deger2  = '0;
      d_yasal   = 1'b0;
      case (opcode)
         OPC_OP: begin
            d_deger1 = rs1_deger_i;
            d_deger2 = rs2_deger_i;
            d_yasal  = 1'b1;
            if (funct7 == F7_SIFIR) begin
               case (funct3)
                  3'b000:  d_kontrol = `AMB_TOPLAMA;
                  3'b001:  d_kontrol = `AMB_SLL;
                  3'b010:  d_kontrol = `AMB_SLT;
                  3'b011:  d_kontrol = `AMB_SLTU;
                  3'b100:  d_kontrol = `AMB_XOR;
                  3'b101:  d_kontrol = `AMB_SRL;
                  3'b110:  d_kontrol = `AMB_OR;
                  default: d_kontrol = `AMB_AND;
               endcase
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               d_kontrol = `AMB_CIKARMA;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               d_kontrol = `AMB_SRA;
            end else begin
               d_yasal = 1'b0;
            end
         end
         OPC_OP_IMM: begin
            d_deger1 = rs1_deger_i;
            d_deger2 = imm_i;
            d_yasal  = 1'b1;
            case (funct3)
               3'b000: d_kontrol = `AMB_TOPLAMA;
               3'b010: d_kontrol = `AMB_SLT;
               3'b011: d_kontrol = `AMB_SLTU;
               3'b100: d_kontrol = `AMB_XOR;
               3'b110: d_kontrol = `AMB_OR;
               3'b111: d_kontrol = `AMB_AND;
               3'b001: begin
                  d_deger2 = shamt;
                  if (funct7 == F7_SIFIR) d_kontrol = `AMB_SLL;
                  else                    d_yasal   = 1'b0;
               end
               default: begin
                  d_deger2 = shamt;
                  if (funct7 == F7_SIFIR)    d_kontrol = `AMB_SRL;
                  else if (funct7 == F7_ALT) d_kontrol = `AMB_SRA;
                  else                       d_yasal   = 1'b0;
               end
            endcase
         end
         OPC_LUI: begin
            d_kontrol = `AMB_GECIR;
            d_deger2  = imm_u;
            d_yasal   = 1'b1;
         end
         OPC_AUIPC: begin
            d_kontrol = `AMB_TOPLAMA;
            d_deger1  = ps_i;
            d_deger2  = imm_u;
            d_yasal   = 1'b1;
         end
         default: d_yasal = 1'b0;
      endcase
      // Illegal instructions travel downstream as a harmless pass-through.
      if (!d_yasal) begin
         d_kontrol = `AMB_GECIR;
         d_deger1  = '0;
         d_deger2  = '0;
      end
   end

   assign d_yaz = d_yasal && (rd != 5'd0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gecerli_o <= 1'b0;
         kontrol_o <= `AMB_GECIR;
         deger1_o  <= '0;
         deger2_o  <= '0;
         rd_o      <= '0;
         yaz_o     <= 1'b0;
         hata_o    <= 1'b0;
      end else if (bosalt_i) begin
         gecerli_o <= 1'b0;
      end else if (kabul) begin
         gecerli_o <= 1'b1;
         kontrol_o <= d_kontrol;
         deger1_o  <= d_deger1;
         deger2_o  <= d_deger2;
         rd_o      <= rd;
         yaz_o     <= d_yaz;
         hata_o    <= !d_yasal;
      end else if (hazir_i) begin
         gecerli_o <= 1'b0;
      end
   end

`ifdef AMB_COZUCU_HATA_SAYACI_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hata_sayisi_o <= '0;
      end else if (kabul && !d_yasal && hata_sayisi_o != 16'hFFFF) begin
         hata_sayisi_o <= hata_sayisi_o + 16'd1;
      end
   end
`endif

endmodule

// File: doc/amb_cozucu.md
Name: amb_cozucu

Overview:
- Decode-to-execute stage register: decodes RV32I ALU-class instructions (OP, OP-IMM, LUI, AUIPC) into the AMB control code and operands.
- Presents decoded fields one cycle later to aritmetik_mantik_birimi.
- It is the producer side of the AMB kontrol/deger interface.
- Valid/ready handshake on both sides, with flush support from the branch unit.

Parameters:
- VERI_GENISLIGI, 32, operand/data width; only 32 is supported.

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous active-high reset
- buyruk_i  input  32  instruction word
- ps_i  input  32  program counter of buyruk_i
- rs1_deger_i  input  32  register-file value for rs1
- rs2_deger_i  input  32  register-file value for rs2
- gecerli_i  input  1  upstream valid
- hazir_o  output  1  upstream ready
- bosalt_i  input  1  flush: discard held and incoming instruction
- kontrol_o  output  4  AMB code (`AMB_* macros from tanimlamalar.vh)
- deger1_o  output  32  AMB operand 1
- deger2_o  output  32  AMB operand 2
- rd_o  output  5  destination register
- yaz_o  output  1  register write enable
- hata_o  output  1  illegal/unsupported instruction
- gecerli_o  output  1  downstream valid
- hazir_i  input  1  downstream ready

Behaviour:
- Reset (rst_i=1 at edge): gecerli_o=0, kontrol_o=`AMB_GECIR, deger1_o=deger2_o=0, rd_o=0, yaz_o=0, hata_o=0. Reset overrides everything, including mid-backpressure.
- hazir_o = !gecerli_o || hazir_i (combinational).
- Accept = gecerli_i && hazir_o && !bosalt_i. On accept, all outputs load next edge (latency 1), gecerli_o=1.
- gecerli_o && !hazir_i: all outputs held bit-stable; no input is accepted.
- gecerli_o && hazir_i && no accept: gecerli_o=0 next edge; data outputs hold their last value.
- bosalt_i=1: gecerli_o=0 next edge regardless of gecerli_i/hazir_i; a simultaneous incoming instruction is dropped. Priority: rst_i > bosalt_i > accept > hold.
- OP (opcode 0110011): deger1=rs1, deger2=rs2.
  - funct7=0000000: funct3 000 TOPLAMA, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: funct3 000 CIKARMA, 101 SRA.
  - Any other funct7/funct3 combination is illegal.
- OP-IMM (0010011): deger1=rs1, deger2=sign-extended imm[11:0]. funct3 map as OP, except 000 is always TOPLAMA.
  - SLLI: imm[11:5] must be 0000000.
  - SRLI/SRAI: imm[11:5] must be 0000000 or 0100000 (the latter selects SRA).
  - deger2 for shifts = zero-extended shamt imm[4:0].
- LUI (0110111): kontrol=GECIR, deger1=0, deger2={buyruk[31:12],12'b0}.
- AUIPC (0010111): kontrol=TOPLAMA, deger1=ps_i, deger2={buyruk[31:12],12'b0}.
- Illegal (any other opcode or invalid funct): hata_o=1, yaz_o=0, kontrol=GECIR, deger1=deger2=0, rd_o=buyruk[11:7]. Still passed downstream with gecerli_o=1.
- yaz_o=1 only for legal decodes with rd≠0; rd=x0 gives yaz_o=0 (kontrol/operands still decoded).
- No combinational path from buyruk_i to any output; hazir_o depends only on gecerli_o and hazir_i.

Optional Feature:
- Macro AMB_COZUCU_HATA_SAYACI_EN.
- Defined: adds output hata_sayisi_o [15:0].
  - Increments by 1 on each accepted illegal instruction; saturates at 0xFFFF.
  - Not affected by bosalt_i after acceptance; cleared by rst_i.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=80, rs2=70, gecerli_i=1, hazir_i=1 -> next cycle gecerli_o=1, kontrol=`AMB_TOPLAMA, deger1=80, deger2=70, rd_o=3, yaz_o=1, hata_o=0.
- SRAI x5,x6,4 (0x40435293), rs1=0xF0F0F0F0 -> kontrol=`AMB_SRA, deger1=0xF0F0F0F0, deger2=4, rd_o=5. LUI x1 (0xF0F0F0B7) -> kontrol=`AMB_GECIR, deger1=0, deger2=0xF0F0F000.
- AUIPC x2 (0x00001117), ps_i=0x100 -> kontrol=`AMB_TOPLAMA, deger1=0x100, deger2=0x1000. ADDI x0,x0,1 (0x00100013) -> yaz_o=0, hata_o=0.
- 0xFFFFFFFF and SLLI with imm[11:5]=0100000 (0x40109093) -> hata_o=1, yaz_o=0, gecerli_o=1. With macro defined, hata_sayisi_o=2.
- Backpressure: hold hazir_i=0 for 3 cycles after a valid output, offering a new instruction -> hazir_o=0, outputs unchanged. Raise hazir_i -> new instruction appears the cycle after acceptance.
- bosalt_i=1 with gecerli_i=1 and gecerli_o=1 -> gecerli_o=0 next cycle, incoming dropped. rst_i mid-hold -> all outputs at reset values next cycle.
